// File: rtl/ahb_ram_pkg.sv
// Shared bus codes, FSM state encoding and the byte-lane mask helper
// used by the parametrised AHB-Lite RAM slave.
package ahb_ram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_DATA = 2'd1;
    localparam state_t ST_ERR1 = 2'd2;
    localparam state_t ST_ERR2 = 2'd3;

    // Lanes touched by a 2**hsize byte transfer starting at byte offset, clipped to the bus width.
    function automatic logic [7:0] lane_mask(input logic [2:0] offset,
                                             input logic [2:0] hsize,
                                             input int         bytes);
        int         lo;
        int         hi;
        logic [7:0] mask;
        lo   = int'(offset);
        hi   = lo + (1 << hsize);
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            mask[i] = (i < bytes) && (i >= lo) && (i < hi);
        end
        return mask;
    endfunction

endpackage

// File: rtl/ahb_ram_lane.sv
// One byte lane of the RAM: simple dual-port storage with a write port and a
// registered read port that holds its last result while re is low.
module ahb_ram_lane #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [0:(1 << ADDR_W) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Same-address read during a write returns the old byte; the top forwards around this.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ahb_ram_param.sv
// AHB-Lite RAM slave: 32/64-bit data, configurable wait states, two-cycle ERROR
// response for misaligned/oversize transfers, byte-lane storage with forwarding.
module ahb_ram_param
    import ahb_ram_pkg::*;
#(
    parameter int RAM_SIZE    = 65536,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 0,
    parameter int ERR_CHECK   = 1
) (
    input  logic                  CLK,
    input  logic                  RES,
    input  logic                  S_HSEL,
    input  logic [1:0]            S_HTRANS,
    input  logic                  S_HWRITE,
    input  logic                  S_HMASTLOCK,
    input  logic [2:0]            S_HSIZE,
    input  logic [2:0]            S_HBURST,
    input  logic [3:0]            S_HPROT,
    input  logic [31:0]           S_HADDR,
    input  logic [DATA_WIDTH-1:0] S_HWDATA,
    input  logic                  S_HREADY,
    output logic                  S_HREADYOUT,
    output logic [DATA_WIDTH-1:0] S_HRDATA,
    output logic                  S_HRESP
);

    localparam int         BYTES     = DATA_WIDTH / 8;
    localparam int         LANE_BITS = $clog2(BYTES);
    localparam int         RAM_ADDR  = $clog2(RAM_SIZE);
    localparam int         WORD_BITS = RAM_ADDR - LANE_BITS;
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);
    localparam logic [2:0] MAX_SIZE  = 3'(LANE_BITS);

    state_t                state;
    state_t                state_next;
    logic [3:0]            wait_cnt;
    logic [RAM_ADDR-1:0]   addr_q;
    logic                  write_q;
    logic [2:0]            size_q;
    logic                  legal_q;

    logic                  trans_active;
    logic                  done;
    logic                  can_accept;
    logic                  accept;
    logic                  legal_in;
    logic [31:0]           align_mask;

    logic [7:0]            mask_full;
    logic [BYTES-1:0]      lane_we;
    logic                  wr_commit;
    logic [WORD_BITS-1:0]  wr_word;
    logic [WORD_BITS-1:0]  rd_word;
    logic                  rd_en;
    logic                  fwd_hit;
    logic [BYTES-1:0]      fwd_en;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [DATA_WIDTH-1:0] lane_rdata;
    logic [DATA_WIDTH-1:0] merged;

    logic                  unused_inputs;

    assign unused_inputs = ^{S_HMASTLOCK, S_HBURST, S_HPROT, S_HADDR, mask_full};

    // Only NONSEQ/SEQ start a transfer; a new address phase is taken only when this slave is ready.
    assign trans_active = (S_HTRANS == HTRANS_NONSEQ) || (S_HTRANS == HTRANS_SEQ);
    assign done         = (state == ST_DATA) && (wait_cnt == WAIT_LAST);
    assign can_accept   = (state == ST_IDLE) || (state == ST_ERR2) || done;
    assign accept       = can_accept && S_HSEL && S_HREADY && trans_active;

    always_comb begin
        align_mask = (32'd1 << S_HSIZE) - 32'd1;
        if (ERR_CHECK == 0) begin
            legal_in = 1'b1;
        end else begin
            legal_in = (S_HSIZE <= MAX_SIZE) && ((S_HADDR & align_mask) == 32'd0);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_ERR1: state_next = ST_ERR2;
            ST_DATA: begin
                if (done) begin
                    state_next = accept ? (legal_in ? ST_DATA : ST_ERR1) : ST_IDLE;
                end
            end
            default: state_next = accept ? (legal_in ? ST_DATA : ST_ERR1) : ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= 3'd0;
            legal_q  <= 1'b0;
            fwd_en   <= '0;
            fwd_data <= '0;
        end else begin
            state <= state_next;
            if ((state == ST_DATA) && !done) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= 4'd0;
            end
            if (accept) begin
                addr_q  <= S_HADDR[RAM_ADDR-1:0];
                write_q <= S_HWRITE;
                size_q  <= S_HSIZE;
                legal_q <= legal_in;
            end
            fwd_en   <= fwd_hit ? lane_we : '0;
            fwd_data <= fwd_hit ? S_HWDATA : '0;
        end
    end

    // A reset in the completing cycle must still suppress the write.
    assign wr_commit = done && write_q && legal_q && !RES;
    assign wr_word   = addr_q[RAM_ADDR-1:LANE_BITS];
    assign mask_full = lane_mask(3'(addr_q[LANE_BITS-1:0]), size_q, BYTES);
    assign lane_we   = wr_commit ? mask_full[BYTES-1:0] : '0;

    generate
        if (WAIT_CYCLES == 0) begin : g_rd_at_accept
            assign rd_en   = accept && !S_HWRITE;
            assign rd_word = S_HADDR[RAM_ADDR-1:LANE_BITS];
        end else begin : g_rd_in_data
            assign rd_en   = (state == ST_DATA) && (wait_cnt == 4'd0) && !write_q;
            assign rd_word = addr_q[RAM_ADDR-1:LANE_BITS];
        end
    endgenerate

    assign fwd_hit = rd_en && wr_commit && (rd_word == wr_word);

    generate
        for (genvar i = 0; i < BYTES; i++) begin : g_lane
            ahb_ram_lane #(
                .ADDR_W(WORD_BITS)
            ) u_lane (
                .clk   (CLK),
                .we    (lane_we[i]),
                .waddr (wr_word),
                .wdata (S_HWDATA[8*i +: 8]),
                .re    (rd_en),
                .raddr (rd_word),
                .rdata (lane_rdata[8*i +: 8])
            );
            assign merged[8*i +: 8] = fwd_en[i] ? fwd_data[8*i +: 8] : lane_rdata[8*i +: 8];
        end
    endgenerate

    always_comb begin
        S_HREADYOUT = 1'b1;
        S_HRESP     = HRESP_OKAY;
        case (state)
            ST_DATA: S_HREADYOUT = done;
            ST_ERR1: begin
                S_HREADYOUT = 1'b0;
                S_HRESP     = HRESP_ERROR;
            end
            ST_ERR2: S_HRESP = HRESP_ERROR;
            default: ;
        endcase
    end

    assign S_HRDATA = (done && !write_q && legal_q) ? merged : '0;

endmodule

// File: tb/tb_ahb_ram_param.sv
// Directed bench for ahb_ram_param: three slaves (32-bit/0 wait, 32-bit/3 wait,
// 64-bit/3 wait) share one master bus and are selected one at a time.
module tb_ahb_ram_param;
    import ahb_ram_pkg::*;

    logic        clk    = 1'b0;
    logic        res    = 1'b1;
    logic [2:0]  sel    = 3'b000;
    logic [1:0]  htrans = HTRANS_IDLE;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize  = HSIZE_WORD;
    logic [31:0] haddr  = 32'd0;
    logic [63:0] hwdata = 64'd0;

    logic        ready0, ready1, ready2;
    logic        resp0, resp1, resp2;
    logic [31:0] rd0, rd1;
    logic [63:0] rd2;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ahb_ram_param #(.RAM_SIZE(65536), .DATA_WIDTH(32), .WAIT_CYCLES(0), .ERR_CHECK(1)) u_dut0 (
        .CLK(clk), .RES(res), .S_HSEL(sel[0]), .S_HTRANS(htrans), .S_HWRITE(hwrite),
        .S_HMASTLOCK(1'b0), .S_HSIZE(hsize), .S_HBURST(3'b000), .S_HPROT(4'b0011),
        .S_HADDR(haddr), .S_HWDATA(hwdata[31:0]), .S_HREADY(ready0),
        .S_HREADYOUT(ready0), .S_HRDATA(rd0), .S_HRESP(resp0)
    );

    ahb_ram_param #(.RAM_SIZE(4096), .DATA_WIDTH(32), .WAIT_CYCLES(3), .ERR_CHECK(1)) u_dut1 (
        .CLK(clk), .RES(res), .S_HSEL(sel[1]), .S_HTRANS(htrans), .S_HWRITE(hwrite),
        .S_HMASTLOCK(1'b0), .S_HSIZE(hsize), .S_HBURST(3'b000), .S_HPROT(4'b0011),
        .S_HADDR(haddr), .S_HWDATA(hwdata[31:0]), .S_HREADY(ready1),
        .S_HREADYOUT(ready1), .S_HRDATA(rd1), .S_HRESP(resp1)
    );

    ahb_ram_param #(.RAM_SIZE(4096), .DATA_WIDTH(64), .WAIT_CYCLES(3), .ERR_CHECK(1)) u_dut2 (
        .CLK(clk), .RES(res), .S_HSEL(sel[2]), .S_HTRANS(htrans), .S_HWRITE(hwrite),
        .S_HMASTLOCK(1'b0), .S_HSIZE(hsize), .S_HBURST(3'b000), .S_HPROT(4'b0011),
        .S_HADDR(haddr), .S_HWDATA(hwdata), .S_HREADY(ready2),
        .S_HREADYOUT(ready2), .S_HRDATA(rd2), .S_HRESP(resp2)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int d, input logic wr, input logic [2:0] sz, input logic [31:0] a);
        sel    = 3'b000;
        sel[d] = 1'b1;
        htrans = HTRANS_NONSEQ;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
    endtask

    task automatic set_idle();
        sel    = 3'b000;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
    endtask

    task automatic test_reset();
        res = 1'b1;
        set_idle();
        repeat (3) cycle();
        res = 1'b0;
        @(negedge clk);
        total++; if (ready0 !== 1'b1) $display("[TB] FAIL reset_ready0: got %b want 1", ready0); else passed++;
        total++; if (resp0 !== 1'b0) $display("[TB] FAIL reset_resp0: got %b want 0", resp0); else passed++;
        total++; if (rd0 !== 32'd0) $display("[TB] FAIL reset_rdata0: got %h want 0", rd0); else passed++;
        total++; if (ready1 !== 1'b1) $display("[TB] FAIL reset_ready1: got %b want 1", ready1); else passed++;
        total++; if (resp2 !== 1'b0) $display("[TB] FAIL reset_resp2: got %b want 0", resp2); else passed++;
        total++; if (rd2 !== 64'd0) $display("[TB] FAIL reset_rdata2: got %h want 0", rd2); else passed++;
    endtask

    task automatic test_write_read();
        set_addr(0, 1'b1, HSIZE_WORD, 32'h100);
        cycle();
        hwdata = 64'h11223344;
        set_idle();
        @(negedge clk);
        total++; if (ready0 !== 1'b1) $display("[TB] FAIL wr_ready: got %b want 1", ready0); else passed++;
        total++; if (rd0 !== 32'd0) $display("[TB] FAIL wr_rdata_zero: got %h want 0", rd0); else passed++;
        cycle();
        set_addr(0, 1'b0, HSIZE_WORD, 32'h100);
        cycle();
        set_idle();
        @(negedge clk);
        total++; if (rd0 !== 32'h11223344) $display("[TB] FAIL rd_word: got %h want 11223344", rd0); else passed++;
        total++; if (resp0 !== 1'b0) $display("[TB] FAIL rd_resp: got %b want 0", resp0); else passed++;
        cycle();
        @(negedge clk);
        total++; if (rd0 !== 32'd0) $display("[TB] FAIL rd_after_zero: got %h want 0", rd0); else passed++;
    endtask

    task automatic test_byte_write();
        set_addr(0, 1'b1, HSIZE_BYTE, 32'h102);
        cycle();
        hwdata = 64'h00AA0000;
        set_idle();
        cycle();
        set_addr(0, 1'b0, HSIZE_WORD, 32'h100);
        cycle();
        set_idle();
        @(negedge clk);
        total++; if (rd0 !== 32'h11AA3344) $display("[TB] FAIL byte_write: got %h want 11aa3344", rd0); else passed++;
        cycle();
        set_addr(0, 1'b1, HSIZE_HALF, 32'h100);
        cycle();
        hwdata = 64'hFFFF5566;
        set_idle();
        cycle();
        set_addr(0, 1'b0, HSIZE_WORD, 32'h100);
        cycle();
        set_idle();
        @(negedge clk);
        total++; if (rd0 !== 32'h11AA5566) $display("[TB] FAIL half_write: got %h want 11aa5566", rd0); else passed++;
        cycle();
    endtask

    task automatic test_back_to_back();
        set_addr(0, 1'b1, HSIZE_WORD, 32'h200);
        cycle();
        hwdata = 64'hDEADBEEF;
        set_addr(0, 1'b0, HSIZE_WORD, 32'h200);
        @(negedge clk);
        total++; if (ready0 !== 1'b1) $display("[TB] FAIL b2b_no_stall: got %b want 1", ready0); else passed++;
        cycle();
        set_idle();
        @(negedge clk);
        total++; if (rd0 !== 32'hDEADBEEF) $display("[TB] FAIL b2b_forward: got %h want deadbeef", rd0); else passed++;
        cycle();
        set_addr(0, 1'b1, HSIZE_BYTE, 32'h201);
        cycle();
        hwdata = 64'h00007700;
        set_addr(0, 1'b0, HSIZE_WORD, 32'h200);
        cycle();
        set_idle();
        @(negedge clk);
        total++; if (rd0 !== 32'hDEAD77EF) $display("[TB] FAIL b2b_lane_forward: got %h want dead77ef", rd0); else passed++;
        cycle();
        set_addr(0, 1'b0, HSIZE_WORD, 32'h100);
        cycle();
        set_addr(0, 1'b0, HSIZE_WORD, 32'h200);
        @(negedge clk);
        total++; if (rd0 !== 32'h11AA5566) $display("[TB] FAIL b2b_read1: got %h want 11aa5566", rd0); else passed++;
        cycle();
        set_idle();
        @(negedge clk);
        total++; if (rd0 !== 32'hDEAD77EF) $display("[TB] FAIL b2b_read2: got %h want dead77ef", rd0); else passed++;
        cycle();
    endtask

    task automatic test_error();
        set_addr(0, 1'b0, HSIZE_HALF, 32'h101);
        cycle();
        set_idle();
        @(negedge clk);
        total++; if (ready0 !== 1'b0) $display("[TB] FAIL err1_ready: got %b want 0", ready0); else passed++;
        total++; if (resp0 !== 1'b1) $display("[TB] FAIL err1_resp: got %b want 1", resp0); else passed++;
        total++; if (rd0 !== 32'd0) $display("[TB] FAIL err1_rdata: got %h want 0", rd0); else passed++;
        cycle();
        @(negedge clk);
        total++; if (ready0 !== 1'b1) $display("[TB] FAIL err2_ready: got %b want 1", ready0); else passed++;
        total++; if (resp0 !== 1'b1) $display("[TB] FAIL err2_resp: got %b want 1", resp0); else passed++;
        total++; if (rd0 !== 32'd0) $display("[TB] FAIL err2_rdata: got %h want 0", rd0); else passed++;
        cycle();
        @(negedge clk);
        total++; if (resp0 !== 1'b0) $display("[TB] FAIL err_done_resp: got %b want 0", resp0); else passed++;
        set_addr(0, 1'b1, HSIZE_DWORD, 32'h100);
        cycle();
        hwdata = 64'h99999999_99999999;
        set_idle();
        @(negedge clk);
        total++; if (resp0 !== 1'b1) $display("[TB] FAIL oversize_resp: got %b want 1", resp0); else passed++;
        cycle();
        set_addr(0, 1'b0, HSIZE_WORD, 32'h100);
        cycle();
        set_idle();
        @(negedge clk);
        total++; if (rd0 !== 32'h11AA5566) $display("[TB] FAIL err_no_write: got %h want 11aa5566", rd0); else passed++;
        total++; if (resp0 !== 1'b0) $display("[TB] FAIL err_next_resp: got %b want 0", resp0); else passed++;
        cycle();
    endtask

    task automatic test_ignore();
        sel    = 3'b000;
        htrans = HTRANS_NONSEQ;
        hwrite = 1'b1;
        hsize  = HSIZE_WORD;
        haddr  = 32'h100;
        cycle();
        hwdata = 64'h55555555;
        sel    = 3'b001;
        htrans = HTRANS_BUSY;
        cycle();
        set_idle();
        cycle();
        set_addr(0, 1'b0, HSIZE_WORD, 32'h100);
        cycle();
        set_idle();
        @(negedge clk);
        total++; if (rd0 !== 32'h11AA5566) $display("[TB] FAIL ignore_unselected: got %h want 11aa5566", rd0); else passed++;
        cycle();
    endtask

    task automatic test_wait_states();
        int          n;
        logic [31:0] early;
        set_addr(1, 1'b1, HSIZE_WORD, 32'h40);
        cycle();
        hwdata = 64'hCAFEF00D;
        set_idle();
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n++;
            if (ready1) break;
            cycle();
        end
        total++; if (n !== 4) $display("[TB] FAIL w3_write_cycles: got %0d want 4", n); else passed++;
        cycle();
        set_addr(1, 1'b0, HSIZE_WORD, 32'h40);
        cycle();
        set_idle();
        n = 0;
        early = 32'hFFFFFFFF;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n++;
            if (k == 0) early = rd1;
            if (ready1) break;
            cycle();
        end
        total++; if (n !== 4) $display("[TB] FAIL w3_read_cycles: got %0d want 4", n); else passed++;
        total++; if (early !== 32'd0) $display("[TB] FAIL w3_rdata_wait: got %h want 0", early); else passed++;
        total++; if (rd1 !== 32'hCAFEF00D) $display("[TB] FAIL w3_rdata: got %h want cafef00d", rd1); else passed++;
        total++; if (resp1 !== 1'b0) $display("[TB] FAIL w3_resp: got %b want 0", resp1); else passed++;
        cycle();
    endtask

    task automatic test_wide();
        int n;
        set_addr(2, 1'b1, HSIZE_DWORD, 32'h8);
        cycle();
        hwdata = 64'h0123456789ABCDEF;
        set_idle();
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n++;
            if (ready2) break;
            cycle();
        end
        total++; if (n !== 4) $display("[TB] FAIL w64_write_cycles: got %0d want 4", n); else passed++;
        cycle();
        set_addr(2, 1'b0, HSIZE_WORD, 32'hC);
        cycle();
        set_idle();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ready2) break;
            cycle();
        end
        total++; if (rd2 !== 64'h0123456789ABCDEF) $display("[TB] FAIL w64_word_read: got %h want 0123456789abcdef", rd2); else passed++;
        cycle();
        set_addr(2, 1'b1, HSIZE_WORD, 32'h8);
        cycle();
        hwdata = 64'hFFFFFFFF_FFFFFFFF;
        set_idle();
        cycle();
        res = 1'b1;
        cycle();
        res = 1'b0;
        @(negedge clk);
        total++; if (ready2 !== 1'b1) $display("[TB] FAIL w64_reset_ready: got %b want 1", ready2); else passed++;
        cycle();
        set_addr(2, 1'b0, HSIZE_DWORD, 32'h8);
        cycle();
        set_idle();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ready2) break;
            cycle();
        end
        total++; if (rd2 !== 64'h0123456789ABCDEF) $display("[TB] FAIL w64_reset_no_write: got %h want 0123456789abcdef", rd2); else passed++;
        cycle();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_byte_write();
        test_back_to_back();
        test_error();
        test_ignore();
        test_wait_states();
        test_wide();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
